mc_ctrl: RTL and testbench

- Multi-cycle control FSM for the next-stage MIPS core (P5 multi-cycle datapath).
- Sequences the shared PC, IR, register file, ALU and data memory through fetch, decode, execute, memory and write-back.
- Generates all datapath enables and selects from the IR opcode/funct and the ALU zero flag.
- Also provides a retired-instruction counter and a done pulse, which the status testbenches use to synchronise checks.

---
 rtl/mc_ctrl_pkg.sv | 61 ++++++
 rtl/mc_ctrl_if.sv | 35 +++
 rtl/mc_ctrl_decode.sv | 31 +++
 rtl/mc_ctrl.sv | 140 ++++++++++++++
 tb/tb_mc_ctrl.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: states, instruction
// classes, opcode/funct values and datapath select codes.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB_R     = 4'd7,
    S_WB_I     = 4'd8,
    S_WB_MEM   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  typedef enum logic [3:0] {
    CLS_R_ALU, CLS_JR, CLS_I_ALU, CLS_LOAD, CLS_STORE,
    CLS_BEQ, CLS_J, CLS_JAL, CLS_ILLEGAL
  } cls_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam logic [1:0] NPC_PC4  = 2'd0;
  localparam logic [1:0] NPC_BR   = 2'd1;
  localparam logic [1:0] NPC_JIDX = 2'd2;
  localparam logic [1:0] NPC_RS   = 2'd3;

  localparam logic [1:0] WSEL_RT  = 2'd0;
  localparam logic [1:0] WSEL_RD  = 2'd1;
  localparam logic [1:0] WSEL_RA  = 2'd2;

  localparam logic [1:0] WD_ALU   = 2'd0;
  localparam logic [1:0] WD_MEM   = 2'd1;
  localparam logic [1:0] WD_PC4   = 2'd2;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_OR   = 3'd2;
  localparam logic [2:0] ALU_LUI  = 3'd3;

  localparam logic [1:0] EXT_ZERO = 2'd0;
  localparam logic [1:0] EXT_SIGN = 2'd1;
  localparam logic [1:0] EXT_LUI  = 2'd2;

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath bundle: IR fields and zero flag in, enables/selects
// and status out. The controller side is the master.
interface mc_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             zero;
  logic             pc_we;
  logic [1:0]       npc_sel;
  logic             ir_we;
  logic             rf_we;
  logic [1:0]       rf_wsel;
  logic [1:0]       rf_wdsel;
  logic [2:0]       alu_op;
  logic             alu_bsel;
  logic [1:0]       ext_op;
  logic             dm_we;
  logic             instr_done;
  logic             illegal;
  logic [3:0]       state;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    input  opcode, funct, zero,
    output pc_we, npc_sel, ir_we, rf_we, rf_wsel, rf_wdsel, alu_op,
           alu_bsel, ext_op, dm_we, instr_done, illegal, state, instr_cnt
  );

  modport slave (
    output opcode, funct, zero,
    input  pc_we, npc_sel, ir_we, rf_we, rf_wsel, rf_wdsel, alu_op,
           alu_bsel, ext_op, dm_we, instr_done, illegal, state, instr_cnt
  );
endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction classifier: maps IR opcode/funct onto the small
// set of classes the controller sequences differently.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output cls_t       cls
);

  always_comb begin
    cls = CLS_ILLEGAL;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU, FN_SUBU, FN_SLL: cls = CLS_R_ALU;
          FN_JR:                    cls = CLS_JR;
          default:                  cls = CLS_ILLEGAL;
        endcase
      end
      OP_ORI, OP_LUI: cls = CLS_I_ALU;
      OP_LW:          cls = CLS_LOAD;
      OP_SW:          cls = CLS_STORE;
      OP_BEQ:         cls = CLS_BEQ;
      OP_J:           cls = CLS_J;
      OP_JAL:         cls = CLS_JAL;
      default:        cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/write-back
// and keeps a retired-instruction counter.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic     clk,
  input  logic     rst,
  mc_ctrl_if.master bus
);

  state_t           r_state;
  cls_t             r_cls;
  logic             r_sub;
  logic             r_lui;
  logic [CNT_W-1:0] r_cnt;
  cls_t             w_cls;
  logic             w_done;

  mc_ctrl_decode u_decode (
    .opcode (bus.opcode),
    .funct  (bus.funct),
    .cls    (w_cls)
  );

  // Class and the two sub-op flags are captured in DECODE so later states do
  // not depend on the IR staying put.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_cls   <= CLS_ILLEGAL;
      r_cnt   <= '0;
    end else begin
      if (w_done) r_cnt <= r_cnt + CNT_W'(1);
      case (r_state)
        S_FETCH:  r_state <= S_DECODE;
        S_DECODE: begin
          r_cls <= w_cls;
          r_sub <= (bus.funct == FN_SUBU);
          r_lui <= (bus.opcode == OP_LUI);
          case (w_cls)
            CLS_R_ALU:                 r_state <= S_EXEC_R;
            CLS_I_ALU:                 r_state <= S_EXEC_I;
            CLS_LOAD, CLS_STORE:       r_state <= S_MEM_ADDR;
            CLS_BEQ:                   r_state <= S_BRANCH;
            CLS_J, CLS_JAL, CLS_JR:    r_state <= S_JUMP;
            default:                   r_state <= S_FETCH;
          endcase
        end
        S_EXEC_R:   r_state <= S_WB_R;
        S_EXEC_I:   r_state <= S_WB_I;
        S_MEM_ADDR: r_state <= (r_cls == CLS_STORE) ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD:   r_state <= S_WB_MEM;
        default:    r_state <= S_FETCH;
      endcase
    end
  end

  // Everything below is forced to zero while rst is high, even once the
  // state has already returned to FETCH.
  always_comb begin
    bus.pc_we    = 1'b0;
    bus.npc_sel  = NPC_PC4;
    bus.ir_we    = 1'b0;
    bus.rf_we    = 1'b0;
    bus.rf_wsel  = WSEL_RT;
    bus.rf_wdsel = WD_ALU;
    bus.alu_op   = ALU_ADD;
    bus.alu_bsel = 1'b0;
    bus.ext_op   = EXT_ZERO;
    bus.dm_we    = 1'b0;
    bus.illegal  = 1'b0;
    w_done       = 1'b0;
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          bus.ir_we = 1'b1;
          bus.pc_we = 1'b1;
        end
        S_DECODE: bus.illegal = (w_cls == CLS_ILLEGAL);
        S_EXEC_R: bus.alu_op = r_sub ? ALU_SUB : ALU_ADD;
        S_WB_R: begin
          bus.rf_we   = 1'b1;
          bus.rf_wsel = WSEL_RD;
          w_done      = 1'b1;
        end
        S_EXEC_I: begin
          bus.alu_bsel = 1'b1;
          bus.alu_op   = r_lui ? ALU_LUI : ALU_OR;
          bus.ext_op   = r_lui ? EXT_LUI : EXT_ZERO;
        end
        S_WB_I: begin
          bus.rf_we = 1'b1;
          w_done    = 1'b1;
        end
        S_MEM_ADDR: begin
          bus.alu_bsel = 1'b1;
          bus.ext_op   = EXT_SIGN;
        end
        S_WB_MEM: begin
          bus.rf_we    = 1'b1;
          bus.rf_wdsel = WD_MEM;
          w_done       = 1'b1;
        end
        S_MEM_WR: begin
          bus.dm_we = 1'b1;
          w_done    = 1'b1;
        end
        S_BRANCH: begin
          bus.alu_op  = ALU_SUB;
          bus.ext_op  = EXT_SIGN;
          bus.npc_sel = NPC_BR;
          bus.pc_we   = bus.zero;
          w_done      = 1'b1;
        end
        S_JUMP: begin
          bus.pc_we = 1'b1;
          w_done    = 1'b1;
          if (r_cls == CLS_JR) begin
            bus.npc_sel = NPC_RS;
          end else begin
            bus.npc_sel = NPC_JIDX;
            if (r_cls == CLS_JAL) begin
              bus.rf_we    = 1'b1;
              bus.rf_wsel  = WSEL_RA;
              bus.rf_wdsel = WD_PC4;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.instr_done = w_done;
  assign bus.state      = r_state;
  assign bus.instr_cnt  = r_cnt;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: walks each instruction class through its states
// and checks the decoded controls, retire pulses and the retire counter.
module tb_mc_ctrl;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  mc_ctrl_if #(.CNT_W(32)) bus ();

  mc_ctrl #(.CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ir(input logic [5:0] op, input logic [5:0] fn);
    bus.opcode = op;
    bus.funct  = fn;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.zero = 1'b0;
    set_ir(6'h00, 6'h21);

    // Reset, then the first FETCH as soon as rst drops
    tick(); tick();
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_cnt", bus.instr_cnt, 32'd0);
    chk("rst_ir_we", 32'(bus.ir_we), 32'd0);
    chk("rst_pc_we", 32'(bus.pc_we), 32'd0);
    rst = 1'b0;
    #1;
    chk("fetch_ir_we", 32'(bus.ir_we), 32'd1);
    chk("fetch_pc_we", 32'(bus.pc_we), 32'd1);
    chk("fetch_npc", 32'(bus.npc_sel), 32'd0);

    // addu
    tick();
    chk("addu_dec_state", 32'(bus.state), 32'd1);
    chk("addu_dec_ir_we", 32'(bus.ir_we), 32'd0);
    chk("addu_dec_rf_we", 32'(bus.rf_we), 32'd0);
    tick();
    chk("addu_ex_state", 32'(bus.state), 32'd2);
    chk("addu_ex_alu", 32'(bus.alu_op), 32'd0);
    chk("addu_ex_bsel", 32'(bus.alu_bsel), 32'd0);
    tick();
    chk("addu_wb_state", 32'(bus.state), 32'd7);
    chk("addu_wb_rf_we", 32'(bus.rf_we), 32'd1);
    chk("addu_wb_wsel", 32'(bus.rf_wsel), 32'd1);
    chk("addu_wb_done", 32'(bus.instr_done), 32'd1);
    chk("addu_wb_cnt", bus.instr_cnt, 32'd0);
    set_ir(6'h0d, 6'h00);

    // ori
    tick();
    chk("ori_fetch_state", 32'(bus.state), 32'd0);
    chk("ori_fetch_cnt", bus.instr_cnt, 32'd1);
    chk("ori_fetch_done", 32'(bus.instr_done), 32'd0);
    tick(); tick();
    chk("ori_ex_state", 32'(bus.state), 32'd3);
    chk("ori_ex_alu", 32'(bus.alu_op), 32'd2);
    chk("ori_ex_ext", 32'(bus.ext_op), 32'd0);
    chk("ori_ex_bsel", 32'(bus.alu_bsel), 32'd1);
    tick();
    chk("ori_wb_state", 32'(bus.state), 32'd8);
    chk("ori_wb_rf_we", 32'(bus.rf_we), 32'd1);
    chk("ori_wb_wsel", 32'(bus.rf_wsel), 32'd0);
    chk("ori_wb_done", 32'(bus.instr_done), 32'd1);
    set_ir(6'h23, 6'h00);

    // lw
    tick();
    chk("lw_fetch_cnt", bus.instr_cnt, 32'd2);
    tick(); tick();
    chk("lw_addr_state", 32'(bus.state), 32'd4);
    chk("lw_addr_ext", 32'(bus.ext_op), 32'd1);
    chk("lw_addr_bsel", 32'(bus.alu_bsel), 32'd1);
    chk("lw_addr_done", 32'(bus.instr_done), 32'd0);
    tick();
    chk("lw_rd_state", 32'(bus.state), 32'd5);
    chk("lw_rd_done", 32'(bus.instr_done), 32'd0);
    chk("lw_rd_rf_we", 32'(bus.rf_we), 32'd0);
    tick();
    chk("lw_wb_state", 32'(bus.state), 32'd9);
    chk("lw_wb_wdsel", 32'(bus.rf_wdsel), 32'd1);
    chk("lw_wb_rf_we", 32'(bus.rf_we), 32'd1);
    chk("lw_wb_dm_we", 32'(bus.dm_we), 32'd0);
    chk("lw_wb_done", 32'(bus.instr_done), 32'd1);
    set_ir(6'h2b, 6'h00);

    // sw
    tick();
    chk("sw_fetch_cnt", bus.instr_cnt, 32'd3);
    chk("sw_fetch_dm_we", 32'(bus.dm_we), 32'd0);
    tick(); tick();
    chk("sw_addr_dm_we", 32'(bus.dm_we), 32'd0);
    tick();
    chk("sw_wr_state", 32'(bus.state), 32'd6);
    chk("sw_wr_dm_we", 32'(bus.dm_we), 32'd1);
    chk("sw_wr_rf_we", 32'(bus.rf_we), 32'd0);
    chk("sw_wr_done", 32'(bus.instr_done), 32'd1);
    set_ir(6'h04, 6'h00);
    bus.zero = 1'b1;

    // beq taken
    tick();
    chk("beq1_fetch_cnt", bus.instr_cnt, 32'd4);
    tick(); tick();
    chk("beq1_state", 32'(bus.state), 32'd10);
    chk("beq1_pc_we", 32'(bus.pc_we), 32'd1);
    chk("beq1_npc", 32'(bus.npc_sel), 32'd1);
    chk("beq1_alu", 32'(bus.alu_op), 32'd1);
    chk("beq1_done", 32'(bus.instr_done), 32'd1);
    bus.zero = 1'b0;
    #1;
    chk("beq0_pc_we_live", 32'(bus.pc_we), 32'd0);

    // beq not taken
    tick();
    chk("beq0_fetch_cnt", bus.instr_cnt, 32'd5);
    tick(); tick();
    chk("beq0_state", 32'(bus.state), 32'd10);
    chk("beq0_pc_we", 32'(bus.pc_we), 32'd0);
    chk("beq0_done", 32'(bus.instr_done), 32'd1);
    set_ir(6'h03, 6'h00);

    // jal
    tick();
    chk("jal_fetch_cnt", bus.instr_cnt, 32'd6);
    tick(); tick();
    chk("jal_state", 32'(bus.state), 32'd11);
    chk("jal_pc_we", 32'(bus.pc_we), 32'd1);
    chk("jal_npc", 32'(bus.npc_sel), 32'd2);
    chk("jal_rf_we", 32'(bus.rf_we), 32'd1);
    chk("jal_wsel", 32'(bus.rf_wsel), 32'd2);
    chk("jal_wdsel", 32'(bus.rf_wdsel), 32'd2);
    chk("jal_done", 32'(bus.instr_done), 32'd1);
    set_ir(6'h00, 6'h08);

    // jr
    tick(); tick(); tick();
    chk("jr_state", 32'(bus.state), 32'd11);
    chk("jr_npc", 32'(bus.npc_sel), 32'd3);
    chk("jr_rf_we", 32'(bus.rf_we), 32'd0);
    chk("jr_pc_we", 32'(bus.pc_we), 32'd1);
    set_ir(6'h02, 6'h00);

    // j
    tick();
    chk("j_fetch_cnt", bus.instr_cnt, 32'd8);
    tick(); tick();
    chk("j_npc", 32'(bus.npc_sel), 32'd2);
    chk("j_rf_we", 32'(bus.rf_we), 32'd0);
    set_ir(6'h00, 6'h23);

    // subu
    tick(); tick(); tick();
    chk("subu_ex_state", 32'(bus.state), 32'd2);
    chk("subu_ex_alu", 32'(bus.alu_op), 32'd1);
    set_ir(6'h0f, 6'h00);

    // lui
    tick(); tick(); tick(); tick();
    chk("lui_ex_state", 32'(bus.state), 32'd3);
    chk("lui_ex_alu", 32'(bus.alu_op), 32'd3);
    chk("lui_ex_ext", 32'(bus.ext_op), 32'd2);
    set_ir(6'h3f, 6'h00);

    // Illegal opcode: pulse in DECODE, straight back to FETCH, no retire
    tick(); tick();
    chk("ill_fetch_cnt", bus.instr_cnt, 32'd11);
    chk("ill_fetch_illegal", 32'(bus.illegal), 32'd0);
    tick();
    chk("ill_dec_state", 32'(bus.state), 32'd1);
    chk("ill_dec_illegal", 32'(bus.illegal), 32'd1);
    chk("ill_dec_done", 32'(bus.instr_done), 32'd0);
    tick();
    chk("ill_back_state", 32'(bus.state), 32'd0);
    chk("ill_back_illegal", 32'(bus.illegal), 32'd0);
    chk("ill_back_cnt", bus.instr_cnt, 32'd11);
    set_ir(6'h23, 6'h00);

    // Reset mid-instruction while in MEM_RD
    tick(); tick(); tick();
    chk("mid_rd_state", 32'(bus.state), 32'd5);
    rst = 1'b1;
    tick();
    chk("mid_rst1_state", 32'(bus.state), 32'd0);
    chk("mid_rst1_cnt", bus.instr_cnt, 32'd0);
    chk("mid_rst1_ir_we", 32'(bus.ir_we), 32'd0);
    chk("mid_rst1_pc_we", 32'(bus.pc_we), 32'd0);
    tick();
    chk("mid_rst2_state", 32'(bus.state), 32'd0);
    chk("mid_rst2_rf_we", 32'(bus.rf_we), 32'd0);
    rst = 1'b0;
    #1;
    chk("mid_fetch_ir_we", 32'(bus.ir_we), 32'd1);
    chk("mid_fetch_pc_we", 32'(bus.pc_we), 32'd1);
    tick();
    chk("mid_dec_state", 32'(bus.state), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
